// File: rtl/memgen_arb_2p.sv
// Two-port arbiter/sequencer in front of a single-port 1024x16 MemGen SRAM macro.
// Define MEMGEN_ARB_RR_EN for round-robin arbitration; the default is fixed priority (p0 wins).
module memgen_arb_2p #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  // Request handshake: a request transfers on a cycle where req_valid && req_ready.
  // ready depends combinationally on valid and is never raised toward an idle port.
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  logic grant_p0;
  logic grant_p1;

`ifdef MEMGEN_ARB_RR_EN
  logic rr_ptr;  // 0: p0 preferred, 1: p1 preferred

  always_comb begin
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    if (!reset) begin
      if (p0_req_valid && p1_req_valid) begin
        grant_p0 = ~rr_ptr;
        grant_p1 = rr_ptr;
      end else begin
        grant_p0 = p0_req_valid;
        grant_p1 = p1_req_valid;
      end
    end
  end

  // After any grant the other port becomes preferred.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant_p0) begin
      rr_ptr <= 1'b1;
    end else if (grant_p1) begin
      rr_ptr <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_p0 = ~reset & p0_req_valid;
    grant_p1 = ~reset & p1_req_valid & ~p0_req_valid;
  end
`endif

  assign p0_req_ready = grant_p0;
  assign p1_req_ready = grant_p1;

  logic              acc;
  logic              acc_port;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_comb begin
    acc       = grant_p0 | grant_p1;
    acc_port  = grant_p1;
    acc_we    = grant_p1 ? p1_req_we    : p0_req_we;
    acc_addr  = grant_p1 ? p1_req_addr  : p0_req_addr;
    acc_wdata = grant_p1 ? p1_req_wdata : p0_req_wdata;
  end

  // Command stage: address/data hold their last value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_chip_en <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_chip_en <= acc;
      mem_wr_en   <= acc & acc_we;
      mem_rd_en   <= acc & ~acc_we;
      if (acc) begin
        mem_addr    <= acc_addr;
        mem_wr_data <= acc_wdata;
      end
    end
  end

  // Tag pipeline: stage 1 aligns with the command, stage 2 with mem_rd_data.
  logic tag1_valid, tag1_port, tag1_read;
  logic tag2_valid, tag2_port, tag2_read;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag1_valid <= 1'b0;
      tag1_port  <= 1'b0;
      tag1_read  <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_port  <= 1'b0;
      tag2_read  <= 1'b0;
    end else begin
      tag1_valid <= acc;
      tag1_port  <= acc_port;
      tag1_read  <= ~acc_we;
      tag2_valid <= tag1_valid;
      tag2_port  <= tag1_port;
      tag2_read  <= tag1_read;
    end
  end

  logic rsp_hit;

  always_comb begin
    rsp_hit      = tag2_valid & tag2_read & ~reset;
    p0_rsp_valid = rsp_hit & ~tag2_port;
    p1_rsp_valid = rsp_hit & tag2_port;
    p0_rsp_rdata = p0_rsp_valid ? mem_rd_data : '0;
    p1_rsp_rdata = p1_rsp_valid ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_memgen_arb_2p.sv
// Bench for memgen_arb_2p: directed vector table plus randomized traffic against a reference model.
// Build with or without MEMGEN_ARB_RR_EN; expectations follow the selected policy.
module tb_memgen_arb_2p;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
`ifdef MEMGEN_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic p0_req_valid, p0_req_ready, p0_req_we;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata;
  logic p1_req_valid, p1_req_ready, p1_req_we;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata;
  logic p0_rsp_valid, p1_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic mem_chip_en, mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  always #5 clock = ~clock;

  memgen_arb_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_chip_en(mem_chip_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // SRAM macro: a read command seen in one cycle drives rd_data in the next.
  logic [DATA_W-1:0] sram [0:1023];
  always @(posedge clock) begin
    if (mem_chip_en) begin
      if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
      else if (mem_rd_en) mem_rd_data <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:1023];
  logic [DATA_W-1:0] exp_q[$];
  bit                port_q[$];
  int                due_q[$];
  bit                m_pref;  // 1: p1 preferred
  logic              e_ce, e_we, e_re;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic v0, input logic we0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic we1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      output logic s0, output logic s1, output logic g0, output logic g1);
    logic ev0, ev1, acc, we;
    logic [DATA_W-1:0] ed, d;
    logic [ADDR_W-1:0] a;
    reset = rst;
    p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;
    @(negedge clock);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        if (RR_EN && m_pref) g1 = 1'b1;
        else g0 = 1'b1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    s0 = p0_req_ready;
    s1 = p1_req_ready;
    chk("p0_req_ready", {31'd0, p0_req_ready}, {31'd0, g0});
    chk("p1_req_ready", {31'd0, p1_req_ready}, {31'd0, g1});
    ev0 = 1'b0;
    ev1 = 1'b0;
    ed = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      if (!rst) begin
        if (port_q[0]) ev1 = 1'b1;
        else ev0 = 1'b1;
        ed = exp_q[0];
      end
      void'(due_q.pop_front());
      void'(port_q.pop_front());
      void'(exp_q.pop_front());
    end
    chk("p0_rsp_valid", {31'd0, p0_rsp_valid}, {31'd0, ev0});
    chk("p1_rsp_valid", {31'd0, p1_rsp_valid}, {31'd0, ev1});
    chk("p0_rsp_rdata", {16'd0, p0_rsp_rdata}, ev0 ? {16'd0, ed} : 32'd0);
    chk("p1_rsp_rdata", {16'd0, p1_rsp_rdata}, ev1 ? {16'd0, ed} : 32'd0);
    chk("mem_chip_en", {31'd0, mem_chip_en}, {31'd0, e_ce});
    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e_we});
    chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, e_re});
    chk("mem_addr", {22'd0, mem_addr}, {22'd0, e_addr});
    chk("mem_wr_data", {16'd0, mem_wr_data}, {16'd0, e_wd});
    if (rst) begin
      exp_q.delete();
      port_q.delete();
      due_q.delete();
      m_pref = 1'b0;
      {e_ce, e_we, e_re} = 3'b000;
      e_addr = '0;
      e_wd = '0;
    end else begin
      acc = g0 | g1;
      we = g1 ? we1 : we0;
      a = g1 ? a1 : a0;
      d = g1 ? d1 : d0;
      e_ce = acc;
      e_we = acc & we;
      e_re = acc & ~we;
      if (acc) begin
        e_addr = a;
        e_wd = d;
        if (we) begin
          ref_mem[a] = d;
        end else begin
          exp_q.push_back(ref_mem[a]);
          port_q.push_back(g1);
          due_q.push_back(cyc + 2);
        end
        m_pref = g0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic rst;
    logic v0; logic we0; logic [ADDR_W-1:0] a0; logic [DATA_W-1:0] d0;
    logic v1; logic we1; logic [ADDR_W-1:0] a1; logic [DATA_W-1:0] d1;
    logic r0; logic r1;
  } vec_t;

  function automatic vec_t mk(input logic rst,
                              input logic v0, input logic we0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                              input logic v1, input logic we1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                              input logic r0, input logic r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  vec_t vecs [28];

  initial begin
    logic s0, s1, g0, g1;
    logic pv0, pw0, pv1, pw1;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;

    // Reset held while p0 requests, then the directed scenarios
    for (int i = 0; i < 3; i++) vecs[i] = mk(1, 1, 0, 10'h000, 16'h0, 0, 0, 10'h0, 16'h0, 0, 0);
    vecs[3] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[4] = mk(0, 1, 1, 10'h3FF, 16'hA5A5, 0, 0, 10'h000, 16'h0000, 1, 0);
    vecs[5] = mk(0, 1, 0, 10'h3FF, 16'h0000, 0, 0, 10'h000, 16'h0000, 1, 0);
    vecs[6] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[7] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[8] = mk(0, 1, 1, 10'h001, 16'h1111, 0, 0, 10'h000, 16'h0000, 1, 0);
    vecs[9] = mk(0, 0, 0, 10'h000, 16'h0000, 1, 1, 10'h002, 16'h2222, 0, 1);
    for (int i = 10; i < 16; i++) begin
      vecs[i] = mk(0, 1, 0, 10'h001, 16'h0, 1, 0, 10'h002, 16'h0,
                   RR_EN ? ((i % 2) == 0) : 1'b1, RR_EN ? ((i % 2) == 1) : 1'b0);
    end
    vecs[16] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[17] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[18] = mk(0, 1, 1, 10'h010, 16'hBEEF, 1, 0, 10'h010, 16'h0000, 1, 0);
    vecs[19] = mk(0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h010, 16'h0000, 0, 1);
    vecs[20] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[21] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[22] = mk(0, 1, 0, 10'h001, 16'h0000, 0, 0, 10'h000, 16'h0000, 1, 0);
    vecs[23] = mk(1, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[24] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[25] = mk(0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h002, 16'h0000, 0, 1);
    vecs[26] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    vecs[27] = mk(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);

    // Clock/reset block: one unchecked reset edge to clear unknown state
    reset = 1'b1;
    {p0_req_valid, p0_req_we, p1_req_valid, p1_req_we} = 4'b0000;
    p0_req_addr = '0; p0_req_wdata = '0; p1_req_addr = '0; p1_req_wdata = '0;
    m_pref = 1'b0;
    {e_ce, e_we, e_re} = 3'b000;
    e_addr = '0;
    e_wd = '0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 28; i++) begin
      step(vecs[i].rst, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
           vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1, s0, s1, g0, g1);
      chk($sformatf("vec%0d_p0_ready", i), {31'd0, s0}, {31'd0, vecs[i].r0});
      chk($sformatf("vec%0d_p1_ready", i), {31'd0, s1}, {31'd0, vecs[i].r1});
    end

    // Preload a small address window so random reads hit known data
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 10'(i), 16'($urandom), 0, 0, 10'h0, 16'h0, s0, s1, g0, g1);
    end

    // Randomized traffic: each client holds its request until granted
    pv0 = 0; pw0 = 0; pa0 = '0; pd0 = '0;
    pv1 = 0; pw1 = 0; pa1 = '0; pd1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv0 && $urandom_range(0, 3) != 0) begin
        pv0 = 1; pw0 = 1'($urandom_range(0, 1)); pa0 = 10'($urandom_range(0, 15)); pd0 = 16'($urandom);
      end
      if (!pv1 && $urandom_range(0, 3) != 0) begin
        pv1 = 1; pw1 = 1'($urandom_range(0, 1)); pa1 = 10'($urandom_range(0, 15)); pd1 = 16'($urandom);
      end
      step($urandom_range(0, 99) == 0, pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1, s0, s1, g0, g1);
      if (g0) pv0 = 0;
      if (g1) pv1 = 0;
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0, s0, s1, g0, g1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/memgen_arb_2p.md
# memgen_arb_2p

Two-requester arbiter and sequencer for a single `MemGen_16_10` single-port SRAM macro (1024 x 16). It accepts independent valid/ready read/write requests from two clients, grants one per cycle, and drives the macro's `chip_en`/`wr_en`/`rd_en`/`addr`/`wr_data` from registers. It returns read data to the originating client with a fixed latency. It sits between the macro instance and the two datapath clients in the flat netlist.

## Interface
- `ADDR_W`, 10, address width; must match macro `addr`
- `DATA_W`, 16, data width; must match macro `wr_data`/`rd_data`

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `p0_req_valid` / `p1_req_valid`  in  1  request present
- `p0_req_ready` / `p1_req_ready`  out  1  request accepted this cycle when valid&ready
- `p0_req_we` / `p1_req_we`  in  1  1 = write, 0 = read
- `p0_req_addr` / `p1_req_addr`  in  ADDR_W  word address
- `p0_req_wdata` / `p1_req_wdata`  in  DATA_W  write data
- `p0_rsp_valid` / `p1_rsp_valid`  out  1  one-cycle pulse, read data valid
- `p0_rsp_rdata` / `p1_rsp_rdata`  out  DATA_W  read data; 0 when rsp_valid low
- `mem_chip_en`, `mem_wr_en`, `mem_rd_en`  out  1  to macro
- `mem_addr`  out  ADDR_W  to macro `addr`
- `mem_wr_data`  out  DATA_W  to macro `wr_data`
- `mem_rd_data`  in  DATA_W  from macro `rd_data`

## Operation
- Grant is combinational in cycle T: at most one `pN_req_ready` high, and only if that port's `req_valid` is high. Ready never asserts toward an idle port.
- With no contention, the single valid port is granted every cycle. Full throughput is 1 request/cycle with no bubbles.
- Contention policy is set by the Configuration macro.
- An accepted request is registered into the command stage: `mem_chip_en` = 1; `mem_wr_en` = we; `mem_rd_en` = ~we; `mem_addr`/`mem_wr_data` are the accepted values.
- If nothing is accepted, `mem_chip_en`/`mem_wr_en`/`mem_rd_en` = 0. `mem_addr`/`mem_wr_data` hold their last value.
- Macro contract: a read command presented in cycle T+1 yields `mem_rd_data` valid in cycle T+2.
- A 2-stage tag pipeline (valid, port id, is_read) follows the command. In T+2 the tagged port's `rsp_valid` = 1 and `rsp_rdata` = `mem_rd_data`. The other port's rsp outputs are 0.
- Writes produce no response.
- Ordering is strictly in acceptance order. A read following a write to the same address returns the new data; no forwarding logic is required because the macro serialises.
- No response backpressure: clients must consume `rsp_valid` pulses.

## Timing
- Request-to-response latency: accepted at edge ending T, `rsp_valid` high during T+2. That is 2 cycles.
- Back-to-back reads from alternating ports give alternating `rsp_valid` pulses, one per cycle.
- Reset values: all `mem_*` outputs 0, all `pN_req_ready` 0 during reset, all `rsp_valid`/`rsp_rdata` 0, tag pipeline cleared, round-robin pointer = "p0 preferred".
- Reset asserted mid-operation discards in-flight reads: no `rsp_valid` for commands issued before or during reset.
- First acceptance is possible in the first cycle after `reset` deasserts.
- Simultaneous request from both ports with the same address: resolved purely by policy; the loser stays un-ready and must hold its request stable until accepted.

## Configuration
- `MEMGEN_ARB_RR_EN` defined: round-robin arbitration.
  - One pointer bit names the preferred port.
  - On contention the preferred port wins, and the pointer flips to the other port after any grant to the preferred port.
  - Without contention the pointer moves to the port not just granted.
  - Worst-case wait is 1 cycle.
- Undefined: fixed priority, p0 always wins. The pointer register is not instantiated, and p1 may starve under continuous p0 traffic.

## Test plan
- Reset then idle: all outputs 0; with `reset` held for 3 cycles while p0 requests, no ready and no memory enables.
- p0 write addr 0x3FF data 0xA5A5, then p0 read 0x3FF: write command in T+1 with `mem_wr_en`=1; read gives `p0_rsp_valid` 2 cycles after acceptance with 0xA5A5; `p1_rsp_valid` stays 0.
- Both ports read continuously (p0 addr 0x001 = 0x1111, p1 addr 0x002 = 0x2222 preloaded):
  - RR build: grants alternate p0, p1, p0…; responses alternate 0x1111/0x2222 each cycle.
  - Non-RR build: only p0 is granted and p1 sees no response.
- Same-cycle p0 write 0x010 = 0xBEEF and p1 read 0x010 (RR, p0 preferred): p0 is granted first; the p1 read, accepted next cycle, returns 0xBEEF.
- Reset asserted the cycle after a read acceptance: no `rsp_valid` appears. After deassertion, a new p1 read of a known address returns correct data at latency 2.
